// File: rtl/blink_pkg.sv
// blink_pkg: shared state type and word width for the bit collector
package blink_pkg;
    typedef enum logic {COLLECT, HOLD} coll_state_t;
    localparam int WORD_W = 16;
endpackage

// File: rtl/demux16_bit_collector_slot_decoder.sv
// bit_slot_decoder: one-hot write enable for the word bit the current beat index maps to
module bit_slot_decoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] sel
);
    logic [IDX_W-1:0] pos;
    // WIDTH is a power of two, so WIDTH-1-idx is just the bitwise complement
    always_comb begin
        pos = MSB_FIRST ? ~idx : idx;
        sel = '0;
        sel[pos] = en;
    end
endmodule

// File: rtl/demux16_bit_collector.sv
// demux16_bit_collector: serial bit stream to parallel word with valid/ready on both sides
module demux16_bit_collector import blink_pkg::*; #(
    parameter int WIDTH = WORD_W,
    parameter int IDX_W = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [IDX_W-1:0] bit_index,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready
);
    coll_state_t      state, state_nxt;
    logic             beat;
    logic             last;
    logic [WIDTH-1:0] we;

    assign bit_ready  = state == COLLECT;
    assign word_valid = state == HOLD;
    assign beat       = bit_valid & bit_ready & ~flush;
    assign last       = bit_index == IDX_W'(WIDTH - 1);

    bit_slot_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MSB_FIRST(MSB_FIRST)) u_dec (
        .idx (bit_index),
        .en  (beat),
        .sel (we)
    );

    // next state: flush wins, last beat enters HOLD, consumption returns to COLLECT
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = COLLECT;
        else if (state == COLLECT)
            state_nxt = (beat && last) ? HOLD : COLLECT;
        else
            state_nxt = word_ready ? COLLECT : HOLD;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;

    // beat index counter, wraps naturally at WIDTH
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            bit_index <= '0;
        else if (flush)
            bit_index <= '0;
        else if (beat)
            bit_index <= bit_index + 1'b1;

    // per-bit enable-gated word flops; unwritten bits hold their old value
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            word_out <= '0;
        else
            word_out <= (word_out & ~we) | (we & {WIDTH{bit_in}});
endmodule

// File: tb/tb_demux16_bit_collector.sv
// tb_demux16_bit_collector: randomized and directed checks against a beat-count reference model
module tb_demux16_bit_collector;
    logic        clk = 1'b0;
    logic        rst_n, flush, bit_in, bit_valid, word_ready;
    logic        bit_ready, word_valid, bit_ready_l, word_valid_l;
    logic [3:0]  bit_index, bit_index_l;
    logic [15:0] word_out, word_out_l;

    int checks = 0;
    int failures = 0;

    bit          m_hold;
    int          m_cnt;
    logic [15:0] m_msb, m_lsb;

    demux16_bit_collector #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .bit_index(bit_index), .word_out(word_out),
        .word_valid(word_valid), .word_ready(word_ready)
    );

    demux16_bit_collector #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_l), .bit_index(bit_index_l), .word_out(word_out_l),
        .word_valid(word_valid_l), .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("word_valid", 16'(word_valid), 16'(m_hold));
        chk("bit_ready", 16'(bit_ready), 16'(!m_hold));
        chk("bit_index", 16'(bit_index), 16'(m_cnt));
        chk("word_out", word_out, m_msb);
        chk("word_valid_lsb", 16'(word_valid_l), 16'(m_hold));
        chk("bit_index_lsb", 16'(bit_index_l), 16'(m_cnt));
        chk("word_out_lsb", word_out_l, m_lsb);
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_msb  = '0;
        m_lsb  = '0;
    endtask

    // one clock: the model applies the spec rules to the inputs present at the edge
    task automatic cyc();
        @(posedge clk);
        if (flush) begin
            m_hold = 1'b0;
            m_cnt  = 0;
        end else if (!m_hold) begin
            if (bit_valid) begin
                m_msb[15 - m_cnt] = bit_in;
                m_lsb[m_cnt]      = bit_in;
                m_cnt++;
                if (m_cnt == 16) begin
                    m_cnt  = 0;
                    m_hold = 1'b1;
                end
            end
        end else if (word_ready) begin
            m_hold = 1'b0;
        end
        #1 compare_all();
    endtask

    task automatic send(input logic [15:0] w, input int duty, input int nbeats);
        int k = 0;
        while (k < nbeats) begin
            bit_valid = (duty >= 100) || ($urandom_range(99) < duty);
            bit_in    = bit_valid ? w[15 - k] : 1'($urandom);
            if (bit_valid) k++;
            cyc();
        end
        bit_valid = 1'b0;
    endtask

    task automatic consume();
        word_ready = 1'b1;
        cyc();
        word_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        model_reset();
        #12 compare_all();
        rst_n = 1'b1;

        send(16'hA5C3, 100, 16);
        chk("a5c3_valid", 16'(word_valid), 16'h0001);
        chk("a5c3_word", word_out, 16'hA5C3);

        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            cyc();
        end
        chk("hold_word", word_out, 16'hA5C3);
        chk("hold_ready", 16'(bit_ready), 16'h0000);
        bit_valid = 1'b0;
        consume();
        send(16'h0001, 100, 16);
        chk("w0001", word_out, 16'h0001);
        consume();

        send(16'hFFFF, 50, 16);
        chk("wffff", word_out, 16'hFFFF);
        consume();
        send(16'h8000, 50, 16);
        chk("w8000", word_out, 16'h8000);
        chk("w8000_lsb_first", word_out_l, 16'h0001);
        consume();

        send(16'h5A5A, 100, 7);
        flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        cyc();
        flush = 1'b0; bit_valid = 1'b0;
        chk("flush_idx", 16'(bit_index), 16'h0000);
        send(16'h1234, 100, 16);
        chk("w1234", word_out, 16'h1234);

        flush = 1'b1; word_ready = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        cyc();
        flush = 1'b0; word_ready = 1'b0; bit_valid = 1'b0;
        chk("hold_flush_valid", 16'(word_valid), 16'h0000);
        chk("hold_flush_idx", 16'(bit_index), 16'h0000);
        chk("hold_flush_word", word_out, 16'h1234);

        send(16'hFFFF, 100, 9);
        #1 rst_n = 1'b0;
        model_reset();
        #2 compare_all();
        chk("rst_word", word_out, 16'h0000);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(16'hBEEF, 100, 16);
        chk("wbeef", word_out, 16'hBEEF);
        consume();

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            send(w, 30 + 10 * i, 16);
            chk("rand_word", word_out, w);
            for (int j = 0; j < int'($urandom_range(3)); j++) cyc();
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
